i2c_reg_seq: RTL and testbench
==============================

// Module: i2c_reg_seq
// PURPOSE
//  Transaction sequencer in front of the byte-level I2C driver: turns one
//  register write/read request into the driver's byte sequence.
//  Drives cnd_start/cnd_stop/rw/tx_ack, loads tx_data and pulses tx_start.
//  Collects rx_ack/rx_data and reports done/err/rdata to the CPU-side
//  register block.
// PARAMETERS
//  CLOCK_HZ    27_000_000             system clock, must equal the driver's
//  BAUD        100_000                I2C bit rate, must equal the driver's
//  GAP_CYCLES  2*(CLOCK_HZ/BAUD)+4    post-byte wait: covers ACK + STOP bit
//  RETRY_MAX   3                      retries per request (I2C_SEQ_RETRY_EN only)
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  asynchronous, active-low reset
//  req            in   1  1-cycle request strobe; accepted only when busy=0
//  req_rd         in   1  1=register read, 0=register write
//  req_dev        in   7  7-bit device address
//  req_reg        in   8  register address
//  req_wdata      in   8  write data (write only)
//  busy           out  1  transaction in progress
//  done           out  1  1-cycle pulse at transaction end
//  err            out  1  any NACK in transaction; valid from done until next accepted req
//  rdata          out  8  read result; updated at read completion only
//  i2c_cnd_start  out  1  to driver cnd_start
//  i2c_cnd_stop   out  1  to driver cnd_stop
//  i2c_rw         out  1  to driver rw
//  i2c_tx_data    out  8  to driver tx_data
//  i2c_tx_start   out  1  to driver tx_start (1-cycle pulse)
//  i2c_tx_ack     out  1  to driver tx_ack
//  i2c_tx_ready   in   1  from driver tx_ready
//  i2c_rx_ack     in   1  from driver rx_ack (0=ACK)
//  i2c_rx_data    in   8  from driver rx_data
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - busy=0, done=0, err=0, rdata=8'h00; all i2c_* outputs 0.
//    - Exception: i2c_tx_ack=1.
//    - FSM returns to IDLE and all counters clear, including mid-transaction.
//  - Request capture: req & ~busy latches req_* into internal regs, clears err,
//    sets busy next cycle. req while busy=1 is ignored.
//  - Byte table (byte, start, stop, rw, tx_ack):
//    - Write: B0 {dev,0} S; B1 reg; B2 wdata P. All rw=0.
//    - Read:  B0 {dev,0} S; B1 reg P; B2 {dev,1} S; B3 rw=1, tx_ack=1 (NACK) P.
//  - FSM: IDLE -> ISSUE -> WAIT_LO -> WAIT_HI -> GAP -> (ISSUE next byte | FIN) -> IDLE.
//    - ISSUE: 1 cycle. Present tx_data/cnd_start/cnd_stop/rw/tx_ack and pulse
//      i2c_tx_start. Outputs are held stable until next ISSUE.
//    - WAIT_LO: wait for i2c_tx_ready=0.
//    - WAIT_HI: wait for i2c_tx_ready=1 (data bits sent).
//    - GAP: count GAP_CYCLES. On the last cycle, sample i2c_rx_ack: if rw=0
//      and rx_ack=1, set sticky NACK flag. On the last cycle of B3, rdata <= i2c_rx_data.
//    - FIN: 1 cycle. done=1, busy=0, err=sticky NACK flag.
//  - Byte counter is 2 bits; last byte index = 2 (write) or 3 (read); no wrap.
//  - NACK does not abort: the remaining bytes are still sent, so the bus is
//    always released by STOP.
//  - req in FIN cycle: busy=0, so it is accepted; busy returns to 1 next cycle.
//  - Minimum latency from req to done, write: 3*(1+1+8*CLOCK_HZ/BAUD+GAP_CYCLES)+2 cycles.
// CONFIGURATION
//  Macro I2C_SEQ_RETRY_EN:
//  - Defined: at end of last byte, if NACK flag=1 and retry_cnt<RETRY_MAX,
//    clear flag, retry_cnt++, restart at B0 (no done pulse). Otherwise go to
//    FIN with err=flag.
//  - retry_cnt clears on each accepted req.
//  - Undefined: single attempt; RETRY_MAX unused; no retry counter in RTL.
// TESTING (bench: CLOCK_HZ=1_400_000, BAUD=100_000 -> 14 clk/bit, GAP_CYCLES=32)
//  1. Write: dev=7'h50, reg=8'h10, wdata=8'hA5, device ACKs all ->
//     tx_data seq 8'hA0,8'h10,8'hA5; cnd_start on B0 only; cnd_stop on B2 only;
//     done with err=0.
//  2. Read: dev=7'h50, reg=8'h3C, model returns 8'h5A ->
//     tx_data seq A0,3C,A1,xx; stop on B1/B3; B3 rw=1, tx_ack=1;
//     rdata=8'h5A, err=0.
//  3. NACK on B0 (no device at 7'h22) -> all 3 bytes still issued, B2 with stop;
//     done with err=1. With RETRY_EN: 4 full attempts, then err=1.
//  4. req pulsed while busy (dev=7'h11) -> ignored; sequence of test 1 unchanged;
//     a single done.
//  5. rst_n=0 during B1 GAP -> busy=0, done=0, i2c_tx_start=0 immediately;
//     next write completes normally.
//  6. req in FIN cycle -> done=1 and the new B0 ISSUE occurs 2 cycles later;
//     err of the first transaction cleared.

Source files
------------

// File: rtl/i2c_reg_seq.sv
// Register-level I2C transaction sequencer: expands one write/read request into the
// byte-level driver's start/stop/data sequence. Optional retry logic under I2C_SEQ_RETRY_EN.
module i2c_reg_seq #(
  parameter int unsigned CLOCK_HZ   = 27_000_000,
  parameter int unsigned BAUD       = 100_000,
  parameter int unsigned GAP_CYCLES = 2 * (CLOCK_HZ / BAUD) + 4,
  parameter int unsigned RETRY_MAX  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       req_rd,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rdata,
  output logic       i2c_cnd_start,
  output logic       i2c_cnd_stop,
  output logic       i2c_rw,
  output logic [7:0] i2c_tx_data,
  output logic       i2c_tx_start,
  output logic       i2c_tx_ack,
  input  logic       i2c_tx_ready,
  input  logic       i2c_rx_ack,
  input  logic [7:0] i2c_rx_data
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWaitLo, StWaitHi, StGap, StFin} state_e;

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            nack_q, nack_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [1:0]      byte_q, byte_d;
  logic [GapW-1:0] gap_q, gap_d;

  logic       rd_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wdata_q;

  logic       start_q, stop_q, rw_q, txs_q, txack_q;
  logic [7:0] txd_q;

  logic       tbl_start, tbl_stop, tbl_rw, tbl_ack;
  logic [7:0] tbl_data;

  logic       accept, gap_last;
  logic [1:0] last_byte;

`ifdef I2C_SEQ_RETRY_EN
  localparam int unsigned RetryW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  logic [RetryW-1:0] retry_q, retry_d;
`endif

  assign accept    = req & ~busy_q;
  assign last_byte = rd_q ? 2'd3 : 2'd2;
  assign gap_last  = (gap_q == GapW'(GAP_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    err_d   = err_q;
    nack_d  = nack_q;
    rdata_d = rdata_q;
    byte_d  = byte_q;
    gap_d   = gap_q;
`ifdef I2C_SEQ_RETRY_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      StIdle: begin
        // busy_q set while idle means a request was accepted last cycle
        if (busy_q) begin
          state_d = StIssue;
          byte_d  = 2'd0;
          nack_d  = 1'b0;
        end
      end
      StIssue:  state_d = StWaitLo;
      StWaitLo: if (!i2c_tx_ready) state_d = StWaitHi;
      StWaitHi: begin
        if (i2c_tx_ready) begin
          state_d = StGap;
          gap_d   = '0;
        end
      end
      StGap: begin
        gap_d = gap_q + 1'b1;
        if (gap_last) begin
          if (!rw_q && i2c_rx_ack) nack_d = 1'b1;
          if (byte_q == 2'd3) rdata_d = i2c_rx_data;
          if (byte_q != last_byte) begin
            byte_d  = byte_q + 2'd1;
            state_d = StIssue;
          end else begin
`ifdef I2C_SEQ_RETRY_EN
            if (nack_d && (retry_q < RetryW'(RETRY_MAX))) begin
              nack_d  = 1'b0;
              retry_d = retry_q + 1'b1;
              byte_d  = 2'd0;
              state_d = StIssue;
            end else begin
              state_d = StFin;
            end
`else
            state_d = StFin;
`endif
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StFin) begin
      busy_d = 1'b0;
      err_d  = nack_d;
    end
    if (accept) begin
      busy_d = 1'b1;
      err_d  = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
      retry_d = '0;
`endif
    end
  end

  // Byte table, indexed by the byte about to be issued
  always_comb begin
    tbl_start = 1'b0;
    tbl_stop  = 1'b0;
    tbl_rw    = 1'b0;
    tbl_ack   = 1'b0;
    tbl_data  = 8'h00;
    unique case (byte_d)
      2'd0: begin
        tbl_data  = {dev_q, 1'b0};
        tbl_start = 1'b1;
      end
      2'd1: begin
        tbl_data = reg_q;
        tbl_stop = rd_q;
      end
      2'd2: begin
        if (rd_q) begin
          tbl_data  = {dev_q, 1'b1};
          tbl_start = 1'b1;
        end else begin
          tbl_data = wdata_q;
          tbl_stop = 1'b1;
        end
      end
      default: begin
        tbl_data = 8'hFF;
        tbl_stop = 1'b1;
        tbl_rw   = 1'b1;
        tbl_ack  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      nack_q  <= 1'b0;
      rdata_q <= 8'h00;
      byte_q  <= 2'd0;
      gap_q   <= '0;
`ifdef I2C_SEQ_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      nack_q  <= nack_d;
      rdata_q <= rdata_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
`ifdef I2C_SEQ_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 1'b0;
      dev_q   <= 7'h00;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
    end else if (accept) begin
      rd_q    <= req_rd;
      dev_q   <= req_dev;
      reg_q   <= req_reg;
      wdata_q <= req_wdata;
    end
  end

  // Driver-side controls are loaded on entry to ISSUE and held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      rw_q    <= 1'b0;
      txack_q <= 1'b1;
      txd_q   <= 8'h00;
      txs_q   <= 1'b0;
    end else begin
      txs_q <= (state_d == StIssue);
      if (state_d == StIssue) begin
        start_q <= tbl_start;
        stop_q  <= tbl_stop;
        rw_q    <= tbl_rw;
        txack_q <= tbl_ack;
        txd_q   <= tbl_data;
      end
    end
  end

  assign busy          = busy_q;
  assign done          = (state_q == StFin);
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign i2c_cnd_start = start_q;
  assign i2c_cnd_stop  = stop_q;
  assign i2c_rw        = rw_q;
  assign i2c_tx_data   = txd_q;
  assign i2c_tx_start  = txs_q;
  assign i2c_tx_ack    = txack_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: byte-driver and slave-device model, directed and random
// register transactions checked against a plain-array reference of device contents.
module tb_i2c_reg_seq;

  localparam int unsigned ClkHz   = 1_400_000;
  localparam int unsigned BaudR   = 100_000;
  localparam int          BitClk  = 14;
  localparam int          Gap     = 32;
  localparam int          ByteLat = 2 + 8 * BitClk + Gap;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0, req_rd = 1'b0;
  logic [6:0] req_dev = 7'h00;
  logic [7:0] req_reg = 8'h00, req_wdata = 8'h00;
  logic       busy, done, err;
  logic [7:0] rdata;
  logic       cnd_start, cnd_stop, rw, tx_start, tx_ack;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_ack;
  logic [7:0] rx_data;

  i2c_reg_seq #(.CLOCK_HZ(ClkHz), .BAUD(BaudR)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rd(req_rd), .req_dev(req_dev),
    .req_reg(req_reg), .req_wdata(req_wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .i2c_cnd_start(cnd_start), .i2c_cnd_stop(cnd_stop), .i2c_rw(rw),
    .i2c_tx_data(tx_data), .i2c_tx_start(tx_start), .i2c_tx_ack(tx_ack),
    .i2c_tx_ready(tx_ready), .i2c_rx_ack(rx_ack), .i2c_rx_data(rx_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  function automatic bit present(logic [6:0] d);
    return (d == 7'h50) || (d == 7'h3A);
  endfunction
  function automatic bit didx(logic [6:0] d);
    return (d != 7'h50);
  endfunction

  // Slave device contents (model) and the reference view of the same registers
  logic [7:0] smem [2][256];
  logic [7:0] ref_mem [2][256];
  logic [7:0] rdata_model = 8'h00;

  // Byte driver + slave model; log entries are {start, stop, rw, tx_ack, data}
  logic [11:0] log_q[$];
  int          drv_cnt;
  logic [7:0]  cur_data;
  logic        cur_start, cur_rw;
  logic [6:0]  s_dev;
  logic        s_ok, s_rd, s_phase;
  logic [7:0]  s_ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready <= 1'b1;
      drv_cnt  <= 0;
      rx_ack   <= 1'b1;
      rx_data  <= 8'hFF;
    end else if (drv_cnt == 0) begin
      if (tx_start) begin
        tx_ready  <= 1'b0;
        drv_cnt   <= 8 * BitClk;
        cur_data  <= tx_data;
        cur_start <= cnd_start;
        cur_rw    <= rw;
        log_q.push_back({cnd_start, cnd_stop, rw, tx_ack, tx_data});
      end
    end else begin
      drv_cnt <= drv_cnt - 1;
      if (drv_cnt == 1) begin
        tx_ready <= 1'b1;
        if (cur_start) begin
          s_dev   = cur_data[7:1];
          s_ok    = present(s_dev);
          s_rd    = cur_data[0];
          s_phase = 1'b0;
          rx_ack <= !s_ok;
        end else if (cur_rw) begin
          rx_data <= (s_ok && s_rd) ? smem[didx(s_dev)][s_ptr] : 8'hFF;
          rx_ack  <= 1'b1;
        end else if (!s_ok) begin
          rx_ack <= 1'b1;
        end else begin
          if (!s_phase) begin
            s_ptr   = cur_data;
            s_phase = 1'b1;
          end else begin
            smem[didx(s_dev)][s_ptr] = cur_data;
            s_ptr = s_ptr + 8'd1;
          end
          rx_ack <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic       e_rd;
  logic [6:0] e_dev;
  logic [7:0] e_reg, e_wd;
  int         t_req;

  // Called at a negedge; returns one negedge later with req dropped
  task automatic start_req(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd);
    log_q.delete();
    e_rd = rd; e_dev = dev; e_reg = rg; e_wd = wd;
    req = 1'b1; req_rd = rd; req_dev = dev; req_reg = rg; req_wdata = wd;
    t_req = cyc;
    @(negedge clk);
    req = 1'b0;
  endtask

  function automatic logic [11:0] exp_entry(int b);
    case (b)
      0:       return {3'b100, 1'b0, e_dev, 1'b0};
      1:       return {1'b0, e_rd, 1'b0, 1'b0, e_reg};
      2:       return e_rd ? {3'b100, 1'b0, e_dev, 1'b1} : {3'b010, 1'b0, e_wd};
      default: return 12'h700;
    endcase
  endfunction

  // Waits (bounded) for done and checks the whole transaction against the reference
  task automatic finish_txn(input string tag);
    int n, att, nb;
    bit ok;
    logic [11:0] msk, ent;
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".done"}, done, 1);
    ok  = present(e_dev);
    att = 1;
`ifdef I2C_SEQ_RETRY_EN
    if (!ok) att = 4;
`endif
    nb = e_rd ? 4 : 3;
    chk({tag, ".err"}, err, !ok);
    chk({tag, ".latency"}, cyc - t_req, att * nb * ByteLat + 2);
    chk({tag, ".nbytes"}, log_q.size(), att * nb);
    for (int i = 0; i < log_q.size(); i++) begin
      msk = ((i % nb) == 3) ? 12'hF00 : 12'hEFF;
      ent = exp_entry(i % nb);
      chk($sformatf("%s.byte%0d", tag, i), log_q[i] & msk, ent & msk);
    end
    if (e_rd) rdata_model = ok ? ref_mem[didx(e_dev)][e_reg] : 8'hFF;
    else if (ok) ref_mem[didx(e_dev)][e_reg] = e_wd;
    chk({tag, ".rdata"}, rdata, rdata_model);
  endtask

  task automatic wait_cond_log(input int sz);
    int n = 0;
    while (log_q.size() < sz && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_log", log_q.size() >= sz, 1);
  endtask

  initial begin
    int dc0, n, sel;
    for (int i = 0; i < 256; i++) begin
      smem[0][i] = 8'(i) ^ 8'h33;
      smem[1][i] = ~8'(i);
    end
    smem[0][8'h3C] = 8'h5A;
    ref_mem = smem;

    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.rdata", rdata, 8'h00);
    chk("rst.outs", {cnd_start, cnd_stop, rw, tx_start, tx_data}, 12'h000);
    chk("rst.tx_ack", tx_ack, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: plain write
    start_req(0, 7'h50, 8'h10, 8'hA5);
    finish_txn("t1");
    @(negedge clk);
    // 2: read
    start_req(1, 7'h50, 8'h3C, 8'h00);
    finish_txn("t2");
    @(negedge clk);
    // 3: absent device
    start_req(0, 7'h22, 8'h44, 8'h99);
    finish_txn("t3");
    @(negedge clk);
    // 4: req while busy is ignored
    dc0 = done_cnt;
    start_req(0, 7'h50, 8'h10, 8'hA5);
    wait_cond_log(1);
    req = 1'b1; req_rd = 1'b1; req_dev = 7'h11; req_reg = 8'hEE;
    @(negedge clk);
    req = 1'b0;
    finish_txn("t4");
    repeat (5) @(negedge clk);
    chk("t4.single_done", done_cnt - dc0, 1);
    chk("t4.idle", busy, 0);

    // 5: async reset during B1 gap
    start_req(0, 7'h50, 8'h20, 8'h77);
    wait_cond_log(2);
    n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5.busy", busy, 0);
    chk("t5.done", done, 0);
    chk("t5.tx_start", tx_start, 0);
    chk("t5.rdata", rdata, 8'h00);
    rdata_model = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_req(0, 7'h50, 8'h20, 8'h77);
    finish_txn("t5b");

    // 6: request in the FIN cycle
    @(negedge clk);
    start_req(0, 7'h22, 8'h01, 8'h02);
    finish_txn("t6a");
    start_req(0, 7'h50, 8'h30, 8'h3C);
    chk("t6.busy", busy, 1);
    chk("t6.err_clr", err, 0);
    chk("t6.no_issue_yet", tx_start, 0);
    @(negedge clk);
    chk("t6.issue", {tx_start, tx_data}, 9'h1A0);
    finish_txn("t6b");

    // Randomized transactions
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sel = $urandom_range(0, 2);
      start_req(1'($urandom_range(0, 1)), (sel == 0) ? 7'h50 : (sel == 1) ? 7'h3A : 7'h22,
                8'($urandom_range(0, 15)), 8'($urandom));
      finish_txn($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
